// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 line inputs and decoded key-event outputs of the keyboard receiver
// master: keyboard/consumer side (drives ps2_clk/ps2_data, observes key events)
// slave:  receiver side (samples ps2_clk/ps2_data, drives key events and frame_err)
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;
    modport master (
        output ps2_clk, ps2_data,
        input  key_valid, key_code, key_ext, key_release, frame_err
    );
    modport slave (
        input  ps2_clk, ps2_data,
        output key_valid, key_code, key_ext, key_release, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard frame receiver decoding make/break/extended key events
// Ports: clk, rst (async, active high); bus (slave modport of ps2_keyboard_rx_if):
//   in  ps2_clk, ps2_data (raw, asynchronous)
//   out key_valid (1-cycle strobe), key_code[7:0], key_ext, key_release (held), frame_err (1-cycle strobe)
// Optional: define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES clocks without a fall.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 130000
) (
    input logic              clk,
    input logic              rst,
    ps2_keyboard_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t     state;
    logic [1:0] clk_s, data_s;
    logic       filt;
    logic [7:0] filt_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par, ext_flag, rel_flag;
    logic       fall, timeout, d;

    assign d = data_s[1];
    // the cycle on which the filtered clock is about to drop from 1 to 0
    assign fall = filt && !clk_s[1] && filt_cnt == 8'(FILTER_LEN - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_s    <= 2'b11;
            data_s   <= 2'b11;
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s  <= {clk_s[0], bus.ps2_clk};
            data_s <= {data_s[0], bus.ps2_data};
            if (clk_s[1] == filt)
                filt_cnt <= '0;
            else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                filt     <= clk_s[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 8'd1;
        end

`ifdef PS2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            wd <= '0;
        else
            wd <= (state == IDLE || fall) ? '0 : wd + 1'b1;
    assign timeout = state != IDLE && !fall && wd == WD_W'(TIMEOUT_CYCLES - 1);
`else
    // without the watchdog the timeout parameter has no effect
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            par             <= 1'b0;
            ext_flag        <= 1'b0;
            rel_flag        <= 1'b0;
            bus.key_valid   <= 1'b0;
            bus.key_code    <= '0;
            bus.key_ext     <= 1'b0;
            bus.key_release <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.key_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            if (fall)
                case (state)
                    IDLE: if (!d) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {d, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= d;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (d && ^{shreg, par}) begin
                            if (shreg == 8'hE0)
                                ext_flag <= 1'b1;
                            else if (shreg == 8'hF0)
                                rel_flag <= 1'b1;
                            else begin
                                bus.key_valid   <= 1'b1;
                                bus.key_code    <= shreg;
                                bus.key_ext     <= ext_flag;
                                bus.key_release <= rel_flag;
                                ext_flag        <= 1'b0;
                                rel_flag        <= 1'b0;
                            end
                        end else begin
                            bus.frame_err <= 1'b1;
                            ext_flag      <= 1'b0;
                            rel_flag      <= 1'b0;
                        end
                    end
                endcase
            else if (timeout) begin
                state         <= IDLE;
                bus.frame_err <= 1'b1;
                ext_flag      <= 1'b0;
                rel_flag      <= 1'b0;
            end
        end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed and randomized PS/2 frames checked against an event-level keyboard model
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN = 8;
    localparam int HALF       = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ps2_keyboard_rx_if bus();
    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // event encoding: {frame_err, key_ext, key_release, key_code}; error events carry no key fields
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    logic [9:0]  last_key;
    logic        m_ext, m_rel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && (bus.key_valid || bus.frame_err)) begin
            check("exclusive", 32'(bus.key_valid & bus.frame_err), 32'd0);
            got_q.push_back(bus.frame_err ? 11'h400 : {1'b0, bus.key_ext, bus.key_release, bus.key_code});
        end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_clk(HALF / 2);
        bus.ps2_clk = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk = 1'b1;
        wait_clk(HALF / 2);
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop);
        if (bad_par || !stop) begin
            exp_q.push_back(11'h400);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0)
            m_ext = 1'b1;
        else if (b == 8'hF0)
            m_rel = 1'b1;
        else begin
            last_key = {m_ext, m_rel, b};
            exp_q.push_back({1'b0, last_key});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(stop);
        bus.ps2_data = 1'b1;
        wait_clk(10);
    endtask

    task automatic flush(input string tag);
        wait_clk(20);
        @(negedge clk);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_hold", tag), 32'({bus.key_ext, bus.key_release, bus.key_code}), 32'(last_key));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({bus.key_valid, bus.frame_err, bus.key_ext, bus.key_release, bus.key_code}), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        m_ext        = 1'b0;
        m_rel        = 1'b0;
        last_key     = '0;
        wait_clk(5);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        frame(8'h1C, 1'b0, 1'b1);
        flush("make");

        frame(8'hF0, 1'b0, 1'b1);
        frame(8'h1C, 1'b0, 1'b1);
        flush("break");

        frame(8'hE0, 1'b0, 1'b1);
        frame(8'hF0, 1'b0, 1'b1);
        frame(8'h75, 1'b0, 1'b1);
        frame(8'h1C, 1'b0, 1'b1);
        flush("ext_break");

        frame(8'hF0, 1'b0, 1'b1);
        frame(8'hE0, 1'b0, 1'b1);
        frame(8'hE0, 1'b0, 1'b1);
        frame(8'h6B, 1'b0, 1'b1);
        flush("prefix_order");

        frame(8'hE0, 1'b0, 1'b1);
        frame(8'h1C, 1'b1, 1'b1);
        frame(8'h29, 1'b0, 1'b1);
        flush("parity");

        frame(8'h1C, 1'b0, 1'b0);
        frame(8'h5A, 1'b0, 1'b1);
        flush("stop");

        bus.ps2_clk = 1'b0;
        wait_clk(FILTER_LEN - 3);
        bus.ps2_clk = 1'b1;
        wait_clk(20);
        flush("glitch");

        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'($urandom_range(0, 1)));
        bus.ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst      = 1'b0;
        last_key = '0;
        m_ext    = 1'b0;
        m_rel    = 1'b0;
        flush("after_reset");
        frame(8'h1C, 1'b0, 1'b1);
        flush("reset_recover");

`ifdef PS2_TIMEOUT_EN
        frame(8'hF0, 1'b0, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++)
            send_bit(1'b1);
        wait_clk(1100);
        exp_q.push_back(11'h400);
        m_ext = 1'b0;
        m_rel = 1'b0;
        flush("timeout");
        frame(8'h1C, 1'b0, 1'b1);
        flush("timeout_recover");
`endif

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom);
            case (kind)
                0, 1:    frame(8'hE0, 1'b0, 1'b1);
                2, 3:    frame(8'hF0, 1'b0, 1'b1);
                4:       frame(b, 1'b1, 1'b1);
                5:       frame(b, 1'b0, 1'b0);
                default: frame(b, 1'b0, 1'b1);
            endcase
            if (n % 8 == 7)
                flush($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
